// File: rtl/shift_in.sv
// Serial-to-parallel receiver: start=1, 8 data bits LSB first, stop=0, idle low.
// Define SHIFT_IN_FRAMECHK_EN to reject frames with a bad stop bit and pulse frame_err.
module shift_in #(
  parameter int BIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       ack,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       overrun,
  output logic       frame_err
);

  localparam int M = (BIT_CYCLES - 1) / 2;
  localparam bit SKIP_START = (M == 0);
  localparam logic [3:0] CNT_LAST = 4'(BIT_CYCLES - 1);
  // cnt holds (cycles since t0 - 1) mod BIT_CYCLES, so mid-bit lands on M-1 (mod BIT_CYCLES)
  localparam logic [3:0] SAMP_CNT = (M == 0) ? 4'(BIT_CYCLES - 1) : 4'(M - 1);

  typedef enum logic [2:0] {WAIT_LOW, IDLE, START, DATA, STOP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic       samp;
  logic       cnt_run;
  logic       shift_en;
  logic       stop_samp;
  logic       deliver;

  assign samp = (cnt == SAMP_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_LOW;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_LOW: if (!in) state_nxt = IDLE;
      // With a zero mid-bit offset the start bit is already confirmed by this sample
      IDLE:     if (in) state_nxt = SKIP_START ? DATA : START;
      START:    if (samp) state_nxt = in ? DATA : IDLE;
      DATA:     if (samp && bitcnt == 4'd7) state_nxt = STOP;
      STOP: begin
        if (samp) begin
`ifdef SHIFT_IN_FRAMECHK_EN
          state_nxt = in ? WAIT_LOW : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default:  state_nxt = WAIT_LOW;
    endcase
  end

  always_comb begin
    cnt_run   = (state == START) || (state == DATA) || (state == STOP);
    shift_en  = (state == DATA) && samp;
    stop_samp = (state == STOP) && samp;
`ifdef SHIFT_IN_FRAMECHK_EN
    deliver   = stop_samp && !in;
`else
    deliver   = stop_samp;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      bitcnt <= 4'd0;
    end else if (!cnt_run) begin
      cnt    <= 4'd0;
      bitcnt <= 4'd0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
      if (shift_en) bitcnt <= bitcnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {in, shreg[7:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      if (byte_valid && !ack) begin
        overrun <= 1'b1;
      end else begin
        byte_out   <= shreg;
        byte_valid <= 1'b1;
        if (byte_valid) overrun <= 1'b0;
      end
    end else if (byte_valid && ack) begin
      byte_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

`ifdef SHIFT_IN_FRAMECHK_EN
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= stop_samp && in;
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_in.sv
// Scoreboard bench for shift_in: one instance at 1 clock/bit, one at 4 clocks/bit.
module tb_shift_in;

  logic       clk = 1'b0;
  logic       rst;
  logic       in1, ack1, in4, ack4;
  logic [7:0] bo1, bo4;
  logic       bv1, ov1, fe1, bv4, ov4, fe4;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  shift_in #(.BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .ack(ack1),
    .byte_out(bo1), .byte_valid(bv1), .overrun(ov1), .frame_err(fe1)
  );

  shift_in #(.BIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .ack(ack4),
    .byte_out(bo4), .byte_valid(bv4), .overrun(ov4), .frame_err(fe4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int bc, input logic v);
    if (bc == 1) in1 = v;
    else         in4 = v;
  endtask

  task automatic set_ack(input int bc, input logic v);
    if (bc == 1) ack1 = v;
    else         ack4 = v;
  endtask

  // Drives a frame up to and including the stop-bit sample edge; vb is byte_valid one edge earlier.
  task automatic send(input int bc, input logic [7:0] b, input logic stopb,
                      input bit push, input bit ack_last, output logic vb);
    int m;
    int last;
    m = (bc - 1) / 2;
    last = 9 * bc + m;
    vb = 1'b0;
    if (push) exp_q.push_back(b);
    for (int j = 0; j <= last; j++) begin
      int idx;
      logic v;
      idx = j / bc;
      if (idx == 0)      v = 1'b1;
      else if (idx == 9) v = stopb;
      else               v = b[3'(idx - 1)];
      drive(bc, v);
      if (j == last && ack_last) set_ack(bc, 1'b1);
      step();
      if (j == last - 1) vb = (bc == 1) ? bv1 : bv4;
    end
    set_ack(bc, 1'b0);
  endtask

  task automatic got(input int bc, input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'((bc == 1) ? bo1 : bo4), 32'(e));
    end
  endtask

  initial begin
    logic vb;
    rst = 1'b1; in1 = 1'b0; ack1 = 1'b0; in4 = 1'b0; ack4 = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_bo1", 32'(bo1), 32'h00);
    chk("rst_bv1", 32'(bv1), 32'd0);
    chk("rst_ov1", 32'(ov1), 32'd0);
    chk("rst_fe1", 32'(fe1), 32'd0);
    chk("rst_bv4", 32'(bv4), 32'd0);
    chk("rst_ov4", 32'(ov4), 32'd0);
    step();
    step();

    send(1, 8'hA5, 1'b0, 1'b1, 1'b0, vb);
    chk("a5_early", 32'(vb), 32'd0);
    chk("a5_valid", 32'(bv1), 32'd1);
    got(1, "a5_byte");
    in1 = 1'b0; ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("a5_ack_valid", 32'(bv1), 32'd0);
    chk("a5_ack_hold", 32'(bo1), 32'hA5);

    send(1, 8'h3C, 1'b0, 1'b1, 1'b0, vb);
    chk("3c_valid", 32'(bv1), 32'd1);
    got(1, "3c_byte");
    send(1, 8'hC3, 1'b0, 1'b0, 1'b0, vb);
    in1 = 1'b0;
    chk("ovr_set", 32'(ov1), 32'd1);
    chk("ovr_keep_byte", 32'(bo1), 32'h3C);
    chk("ovr_valid", 32'(bv1), 32'd1);
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("ovr_clear", 32'(ov1), 32'd0);
    chk("ovr_ack_valid", 32'(bv1), 32'd0);

    send(1, 8'h7E, 1'b0, 1'b1, 1'b0, vb);
    got(1, "7e_byte");
    send(1, 8'h81, 1'b0, 1'b1, 1'b1, vb);
    in1 = 1'b0;
    chk("sim_valid", 32'(bv1), 32'd1);
    chk("sim_ovr", 32'(ov1), 32'd0);
    got(1, "81_byte");
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    chk("81_ack_valid", 32'(bv1), 32'd0);

    in1 = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_bo", 32'(bo1), 32'h00);
    chk("midrst_bv", 32'(bv1), 32'd0);
    chk("midrst_ov", 32'(ov1), 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("midrst_no_start", 32'(bv1), 32'd0);
    in1 = 1'b0;
    step();
    send(1, 8'h55, 1'b0, 1'b1, 1'b0, vb);
    in1 = 1'b0;
    chk("55_valid", 32'(bv1), 32'd1);
    got(1, "55_byte");
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;

`ifdef SHIFT_IN_FRAMECHK_EN
    send(1, 8'hFF, 1'b1, 1'b0, 1'b0, vb);
    chk("ferr_pulse", 32'(fe1), 32'd1);
    chk("ferr_no_valid", 32'(bv1), 32'd0);
    chk("ferr_hold_byte", 32'(bo1), 32'h55);
    step();
    chk("ferr_one_cycle", 32'(fe1), 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("ferr_wait_low", 32'(bv1), 32'd0);
    in1 = 1'b0;
    step();
    send(1, 8'h01, 1'b0, 1'b1, 1'b0, vb);
    in1 = 1'b0;
    chk("01_valid", 32'(bv1), 32'd1);
    got(1, "01_byte");
`else
    send(1, 8'hFF, 1'b1, 1'b1, 1'b0, vb);
    in1 = 1'b0;
    chk("nochk_fe", 32'(fe1), 32'd0);
    chk("nochk_valid", 32'(bv1), 32'd1);
    got(1, "ff_byte");
`endif
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;

    in4 = 1'b1;
    step();
    in4 = 1'b0;
    for (int i = 0; i < 45; i++) step();
    chk("glitch_no_valid", 32'(bv4), 32'd0);
    send(4, 8'h96, 1'b0, 1'b1, 1'b0, vb);
    in4 = 1'b0;
    chk("96_not_before_t38", 32'(vb), 32'd0);
    chk("96_valid_t38", 32'(bv4), 32'd1);
    got(4, "96_byte");
    chk("96_fe", 32'(fe4), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
